d_cache_line: RTL
=================

// Module: d_cache_line
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache with multi-word lines and burst refill.
//  Sits between the CPU data port (p_*) and the AXI bridge request port (m_*).
//  Read hits are served in the same cycle. Read misses refill the whole line word by word through an FSM.
//  Uncached (kseg1) accesses bypass the array. Adds line refill, a flush input and a stall-safe handshake.
// PARAMETERS
//  A_WIDTH    32  address width
//  C_INDEX    7   log2(number of lines)
//  LW_LOG     2   log2(words per line); line = 4<<LW_LOG bytes
//  UC_CHECK   1   1: p_a[31:29]==3'b101 is uncached; 0: everything cacheable
// PORTS
//  clk       in   1        clock
//  rst       in   1        synchronous, active-high reset
//  p_a       in   A_WIDTH  CPU byte address
//  p_dout    in   32       CPU write data
//  p_din     out  32       read data to CPU
//  p_strobe  in   1        request valid; held until p_ready
//  p_rw      in   1        0 read, 1 write
//  p_wen     in   4        byte enables (writes)
//  p_size    in   2        access size, passed to memory
//  p_ready   out  1        one-cycle completion pulse
//  flush     in   1        invalidate all lines
//  m_a       out  A_WIDTH  memory address
//  m_din     out  32       memory write data
//  m_dout    in   32       memory read data
//  m_strobe  out  1        memory request; held until m_ready
//  m_rw      out  1        0 read, 1 write
//  m_wen     out  4        memory byte enables; 4'b0000 on reads
//  m_size    out  2        2'b10 on refill beats, else p_size
//  m_ready   in   1        memory beat complete
// BEHAVIOUR
//  Address split: tag = p_a[A_WIDTH-1:C_INDEX+LW_LOG+2], index = p_a[C_INDEX+LW_LOG+1:LW_LOG+2], word = p_a[LW_LOG+1:2].
//  One valid bit per line. Data is stored as 4 byte lanes per word.
//  hit = p_strobe & ~p_rw & cacheable & valid[index] & (tag matches). p_din = stored word. p_ready = 1 in the same cycle while IDLE.
//  FSM states: IDLE, REFILL, WRITE, UNCACHED.
//   IDLE -> REFILL    on a cacheable read miss. Capture the line base and clear beat counter cnt.
//   IDLE -> WRITE     on p_rw=1.
//   IDLE -> UNCACHED  on an uncached read.
//   REFILL: m_a = {base, cnt, 2'b00}, m_strobe = 1, m_rw = 0.
//    Each m_ready writes m_dout into word cnt, then cnt++.
//    After the last beat (cnt == 2^LW_LOG-1): set valid and tag, go to IDLE. The request then hits with no extra p_ready from REFILL.
//    Read-miss latency = 2^LW_LOG memory beats + 1 cycle.
//    valid[index] is cleared on entry, so a partial line is never visible.
//   WRITE: m_a = p_a, m_rw = 1, m_wen = p_wen, m_din = p_dout, m_strobe = 1.
//    On m_ready: p_ready = 1; if the line is valid and the tag matches, update the enabled bytes; go to IDLE. No allocate on a miss.
//   UNCACHED: single read beat at p_a. On m_ready: p_din = m_dout, p_ready = 1, array untouched, go to IDLE.
//  m_* outputs stay stable while m_strobe = 1 and m_ready = 0. m_strobe drops in the cycle after the final m_ready.
//  A new p_strobe may be accepted the cycle after p_ready.
//  flush: clears all valid bits in one cycle. Honoured only in IDLE; if flush and p_strobe arrive together, flush wins and the request waits 1 cycle. Ignored in other states.
//  Reset outputs: p_ready = 0, m_strobe = 0, m_rw = 0, m_wen = 0, m_a = 0, state = IDLE, cnt = 0, all valid = 0.
//  Reset mid-burst abandons the beat. The bridge must tolerate m_strobe dropping.
//  The array has no reset (data and tags X until written).
// TESTING
//  Read 0x0000_0104 on a cold cache, memory returns 0x100+n per beat -> 4 beats at 0x100..0x10C, then p_ready with p_din = 0x0000_0101.
//  Read 0x0000_010C right after the refill -> p_ready in the same cycle, p_din = 0x0000_0103, m_strobe = 0.
//  Write 0xAABBCCDD, wen = 4'b0011 to 0x104 (hit) -> m_strobe write, then a read of 0x104 hits with 0x0000_CCDD.
//  Write to an uncached-tag miss line 0x2000_0100 -> memory write only; a read of 0x100 still hits old data.
//  Read 0xBFAF_F000 twice -> two memory beats, array unchanged, valid[index] unchanged.
//  Assert flush, then read 0x104 -> full 4-beat refill. Assert rst during beat 2 -> m_strobe = 0 next cycle, all lines invalid.

Source files
------------

// File: rtl/d_cache_line.sv
// Direct-mapped write-through, no-write-allocate data cache with word-by-word burst line refill.
// Read hits complete in the request cycle; misses, writes and uncached reads go through the m_* port.
module d_cache_line #(
    parameter int A_WIDTH  = 32,
    parameter int C_INDEX  = 7,
    parameter int LW_LOG   = 2,
    parameter int UC_CHECK = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] p_a,
    input  logic [31:0]        p_dout,
    output logic [31:0]        p_din,
    input  logic               p_strobe,
    input  logic               p_rw,
    input  logic [3:0]         p_wen,
    input  logic [1:0]         p_size,
    output logic               p_ready,
    input  logic               flush,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    input  logic [31:0]        m_dout,
    output logic               m_strobe,
    output logic               m_rw,
    output logic [3:0]         m_wen,
    output logic [1:0]         m_size,
    input  logic               m_ready
);
    localparam int OFF_W  = LW_LOG + 2;
    localparam int TAG_W  = A_WIDTH - C_INDEX - OFF_W;
    localparam int BASE_W = A_WIDTH - OFF_W;
    localparam int LINES  = 1 << C_INDEX;
    localparam int WA_W   = C_INDEX + LW_LOG;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, UNCACHED} state_t;

    state_t             state_q, state_d;
    logic [LW_LOG-1:0]  cnt_q, cnt_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic [LINES-1:0]   valid_q, valid_d;

    logic [3:0][7:0]    data_mem [1 << WA_W];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    logic [TAG_W-1:0]   p_tag;
    logic [C_INDEX-1:0] p_idx;
    logic [LW_LOG-1:0]  p_word;
    logic [C_INDEX-1:0] base_idx;
    logic               cacheable;
    logic               tag_hit;
    logic [31:0]        rd_word;

    logic               data_we;
    logic [WA_W-1:0]    data_waddr;
    logic [31:0]        data_wdat;
    logic [3:0]         data_wbe;
    logic               tag_we;

    assign p_tag     = p_a[A_WIDTH-1 -: TAG_W];
    assign p_idx     = p_a[OFF_W +: C_INDEX];
    assign p_word    = p_a[2 +: LW_LOG];
    assign base_idx  = base_q[C_INDEX-1:0];
    assign cacheable = (UC_CHECK == 0) || (p_a[A_WIDTH-1 -: 3] != 3'b101);
    assign rd_word   = data_mem[{p_idx, p_word}];
    assign tag_hit   = valid_q[p_idx] && (tag_mem[p_idx] == p_tag);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        valid_d    = valid_q;
        p_ready    = 1'b0;
        p_din      = rd_word;
        m_a        = '0;
        m_din      = '0;
        m_strobe   = 1'b0;
        m_rw       = 1'b0;
        m_wen      = 4'b0000;
        m_size     = p_size;
        data_we    = 1'b0;
        data_waddr = {p_idx, p_word};
        data_wdat  = p_dout;
        data_wbe   = 4'b0000;
        tag_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Flush takes priority; a coincident request is simply seen again next cycle.
                if (flush) begin
                    valid_d = '0;
                end else if (p_strobe) begin
                    if (p_rw) begin
                        state_d = WRITE;
                    end else if (!cacheable) begin
                        state_d = UNCACHED;
                    end else if (tag_hit) begin
                        p_ready = 1'b1;
                    end else begin
                        state_d        = REFILL;
                        base_d         = p_a[A_WIDTH-1:OFF_W];
                        cnt_d          = '0;
                        valid_d[p_idx] = 1'b0;
                    end
                end
            end
            REFILL: begin
                m_a      = {base_q, cnt_q, 2'b00};
                m_strobe = 1'b1;
                m_size   = 2'b10;
                if (m_ready) begin
                    data_we    = 1'b1;
                    data_waddr = {base_idx, cnt_q};
                    data_wdat  = m_dout;
                    data_wbe   = 4'b1111;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == {LW_LOG{1'b1}}) begin
                        valid_d[base_idx] = 1'b1;
                        tag_we            = 1'b1;
                        state_d           = IDLE;
                    end
                end
            end
            WRITE: begin
                m_a      = p_a;
                m_din    = p_dout;
                m_strobe = 1'b1;
                m_rw     = 1'b1;
                m_wen    = p_wen;
                if (m_ready) begin
                    p_ready = 1'b1;
                    state_d = IDLE;
                    if (cacheable && tag_hit) begin
                        data_we  = 1'b1;
                        data_wbe = p_wen;
                    end
                end
            end
            UNCACHED: begin
                m_a      = p_a;
                m_strobe = 1'b1;
                if (m_ready) begin
                    p_din   = m_dout;
                    p_ready = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            valid_q <= valid_d;
        end
    end

    // Array storage carries no reset; the valid bits alone decide visibility.
    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_wbe[b]) data_mem[data_waddr][b] <= data_wdat[8*b +: 8];
            end
        end
        if (tag_we) tag_mem[base_idx] <= base_q[BASE_W-1 -: TAG_W];
    end

endmodule
